mc_cpu_core: RTL and testbench

//  Parametrised multi-cycle 32-bit CPU core: the successor to the fixed single-memory lab CPU top.

---
 rtl/mc_cpu_core_if.sv | 30 +++
 rtl/mc_cpu_core.sv | 213 +++++++++++++++++++++
 tb/tb_mc_cpu_core.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_cpu_core_if.sv
// mc_cpu_core_if: instruction and data memory req/ready buses
// of the multi-cycle core, with core (master) and memory (slave) views.
interface mc_cpu_core_if #(
    parameter int ADDR_W = 16
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic [31:0]       imem_rdata;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic              dmem_ready;
    logic [31:0]       dmem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mc_cpu_core.sv
// mc_cpu_core: multi-cycle 32-bit core, IF/ID/EX/MEM/WB FSM with
// handshaked instruction/data memories, HALT and a sized regfile.
module mc_cpu_core #(
    parameter int                ADDR_W   = 16,
    parameter int                NREGS    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    mc_cpu_core_if.master     bus,
    output logic [2:0]        current_state,
    output logic [ADDR_W-1:0] pc_out,
    output logic              retire,
    output logic              halted
);

    localparam int RI_W = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_LW   = 6'b110000;
    localparam logic [5:0] OP_SW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_HLT = 3'd5
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       ir;
    logic [31:0]       a;
    logic [31:0]       b;
    logic [31:0]       imm_x;
    logic [31:0]       aluout;
    logic [31:0]       mdr;
    logic [31:0]       alu_res;
    logic [31:0]       rf [NREGS];
    logic              imem_req;
    logic              dmem_req;
    logic              dmem_we;

    logic [5:0]      op;
    logic [10:0]     func;
    logic [RI_W-1:0] rs;
    logic [RI_W-1:0] rt;
    logic [RI_W-1:0] rd;
    logic [RI_W-1:0] wd;
    logic            is_r;
    logic            is_lw;
    logic            is_sw;
    logic            is_beq;
    logic            is_j;
    logic            is_halt;
    logic            known;

    function automatic logic op_known(input logic [5:0] o);
        return o inside {OP_R, OP_ADDI, OP_LW, OP_SW,
                         OP_BEQ, OP_J, OP_HALT};
    endfunction

    assign op      = ir[31:26];
    assign rs      = ir[21 +: RI_W];
    assign rt      = ir[16 +: RI_W];
    assign rd      = ir[11 +: RI_W];
    assign func    = ir[10:0];
    assign is_r    = (op == OP_R);
    assign is_lw   = (op == OP_LW);
    assign is_sw   = (op == OP_SW);
    assign is_beq  = (op == OP_BEQ);
    assign is_j    = (op == OP_J);
    assign is_halt = (op == OP_HALT);
    assign known   = op_known(op);
    assign wd      = is_r ? rd : rt;

    // ADDI, LW and SW all use rs + sext(imm)
    always_comb begin
        alu_res = a + imm_x;
        if (is_r) begin
            unique case (func)
                11'd1:   alu_res = a + b;
                11'd2:   alu_res = a - b;
                11'd3:   alu_res = a & b;
                11'd4:   alu_res = a | b;
                11'd5:   alu_res = a ^ b;
                11'd6:   alu_res = {31'd0, $signed(a) < $signed(b)};
                default: alu_res = '0;
            endcase
        end
    end

    assign bus.imem_req   = imem_req;
    assign bus.imem_addr  = pc;
    assign bus.dmem_req   = dmem_req;
    assign bus.dmem_we    = dmem_we;
    assign bus.dmem_addr  = {aluout[ADDR_W-1:2], 2'b00};
    assign bus.dmem_wdata = b;
    assign current_state  = state;
    assign pc_out         = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IF;
            pc       <= RESET_PC;
            ir       <= '0;
            a        <= '0;
            b        <= '0;
            imm_x    <= '0;
            aluout   <= '0;
            mdr      <= '0;
            imem_req <= 1'b1;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            retire   <= 1'b0;
            halted   <= 1'b0;
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else begin
            retire <= 1'b0;
            unique case (state)
                S_IF: begin
                    if (bus.imem_ready) begin
                        ir       <= bus.imem_rdata;
                        imem_req <= 1'b0;
                        state    <= S_ID;
                        // unknown ops retire as NOPs during ID
                        retire   <= !op_known(bus.imem_rdata[31:26]);
                    end
                end
                S_ID: begin
                    a     <= rf[rs];
                    b     <= rf[rt];
                    imm_x <= {{16{ir[15]}}, ir[15:0]};
                    unique case (1'b1)
                        is_halt: begin
                            state  <= S_HLT;
                            halted <= 1'b1;
                        end
                        !known: begin
                            pc       <= pc + STEP;
                            imem_req <= 1'b1;
                            state    <= S_IF;
                        end
                        default: begin
                            state  <= S_EX;
                            retire <= is_beq | is_j;
                        end
                    endcase
                end
                S_EX: begin
                    aluout <= alu_res;
                    unique case (1'b1)
                        is_beq: begin
                            pc <= (a == b)
                                ? pc + STEP + ADDR_W'({imm_x[29:0], 2'b00})
                                : pc + STEP;
                            imem_req <= 1'b1;
                            state    <= S_IF;
                        end
                        is_j: begin
                            pc       <= ADDR_W'({ir[25:0], 2'b00});
                            imem_req <= 1'b1;
                            state    <= S_IF;
                        end
                        is_lw, is_sw: begin
                            dmem_req <= 1'b1;
                            dmem_we  <= is_sw;
                            state    <= S_MEM;
                        end
                        default: begin
                            retire <= 1'b1;
                            state  <= S_WB;
                        end
                    endcase
                end
                S_MEM: begin
                    if (bus.dmem_ready) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        retire   <= 1'b1;
                        if (is_sw) begin
                            pc       <= pc + STEP;
                            imem_req <= 1'b1;
                            state    <= S_IF;
                        end else begin
                            mdr   <= bus.dmem_rdata;
                            state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (wd != '0) rf[wd] <= is_lw ? mdr : aluout;
                    pc       <= pc + STEP;
                    imem_req <= 1'b1;
                    state    <= S_IF;
                end
                S_HLT: state <= S_HLT;
                default: begin
                    imem_req <= 1'b1;
                    state    <= S_IF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_cpu_core.sv
// tb_mc_cpu_core: directed and random programs against an ISA-level
// reference model; memories with configurable wait states.
module tb_mc_cpu_core;

    localparam int AW = 16;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_LW   = 6'b110000;
    localparam logic [5:0] OP_SW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [31:0] HALT_W = 32'hFC00_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mc_cpu_core_if #(.ADDR_W(AW)) bus ();
    logic [2:0]    current_state;
    logic [AW-1:0] pc_out;
    logic          retire;
    logic          halted;

    mc_cpu_core #(.ADDR_W(AW), .NREGS(32), .RESET_PC('0)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .current_state (current_state),
        .pc_out        (pc_out),
        .retire        (retire),
        .halted        (halted)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    logic [31:0] prog [256];
    logic [31:0] dmem [logic [15:0]];
    logic [31:0] fetch_q [$];
    logic [31:0] st_a [$];
    logic [31:0] st_d [$];
    int          ret_q [$];
    logic [31:0] exp_f [$];
    logic [31:0] exp_sa [$];
    logic [31:0] exp_sd [$];
    int          exp_ret;
    int          cyc = 0;
    int          iw = 0;
    int          dw = 0;
    int          wmode = 0;
    bit          dstall = 0;
    bit          dcap = 0;
    logic [31:0] dc_addr, dc_wdata, dc_we;

    function automatic logic [31:0] dm_init(input logic [15:0] ad);
        return {16'hC0DE, ad};
    endfunction

    function automatic int nw();
        if (wmode == 1) return int'($urandom_range(0, 3));
        if (wmode == 2) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] ir_r(input int rd, input int rs,
                                         input int rt, input int f);
        return {OP_R, 5'(rs), 5'(rt), 5'(rd), 11'(f)};
    endfunction

    function automatic logic [31:0] i_ty(input logic [5:0] op, input int rt,
                                         input int rs, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    // memory side: decisions made at negedge, away from the active edge
    initial begin
        bus.imem_ready = 1'b0;
        bus.imem_rdata = '0;
        bus.dmem_ready = 1'b0;
        bus.dmem_rdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (retire) ret_q.push_back(cyc);
            bus.imem_ready = 1'b0;
            bus.dmem_ready = 1'b0;
            if (!rst && bus.imem_req) begin
                if (iw == 0) begin
                    bus.imem_ready = 1'b1;
                    bus.imem_rdata = prog[bus.imem_addr[9:2]];
                    fetch_q.push_back(32'(bus.imem_addr));
                    iw = nw();
                end else iw--;
            end
            if (!rst && bus.dmem_req && !dstall) begin
                if (dcap) begin
                    chk("dmem_addr hold", 32'(bus.dmem_addr), dc_addr);
                    chk("dmem_wdata hold", bus.dmem_wdata, dc_wdata);
                    chk("dmem_we hold", 32'(bus.dmem_we), dc_we);
                end
                dcap = 1;
                dc_addr = 32'(bus.dmem_addr);
                dc_wdata = bus.dmem_wdata;
                dc_we = 32'(bus.dmem_we);
                if (dw == 0) begin
                    bus.dmem_ready = 1'b1;
                    if (bus.dmem_we) begin
                        st_a.push_back(32'(bus.dmem_addr));
                        st_d.push_back(bus.dmem_wdata);
                        dmem[bus.dmem_addr] = bus.dmem_wdata;
                    end else begin
                        bus.dmem_rdata = dmem.exists(bus.dmem_addr)
                            ? dmem[bus.dmem_addr] : dm_init(bus.dmem_addr);
                    end
                    dw = nw();
                    dcap = 0;
                end else dw--;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = HALT_W;
    endtask

    task automatic start(input int iw0);
        rst = 1'b1;
        dstall = 0;
        dcap = 0;
        fetch_q.delete();
        st_a.delete();
        st_d.delete();
        ret_q.delete();
        dmem.delete();
        repeat (2) @(posedge clk);
        iw = iw0;
        dw = nw();
        #2;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic run_halt(input string tag, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " halted"}, 32'(halted), 1);
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " rst state"}, 32'(current_state), 0);
        chk({tag, " rst pc"}, 32'(pc_out), 0);
        chk({tag, " rst imem_req"}, 32'(bus.imem_req), 1);
        chk({tag, " rst imem_addr"}, 32'(bus.imem_addr), 0);
        chk({tag, " rst dmem_req"}, 32'(bus.dmem_req), 0);
        chk({tag, " rst dmem_we"}, 32'(bus.dmem_we), 0);
        chk({tag, " rst dmem_addr"}, 32'(bus.dmem_addr), 0);
        chk({tag, " rst dmem_wdata"}, bus.dmem_wdata, 0);
        chk({tag, " rst retire"}, 32'(retire), 0);
        chk({tag, " rst halted"}, 32'(halted), 0);
    endtask

    // instruction-at-a-time interpreter of the program image
    task automatic model_run();
        logic [31:0] r [32];
        logic [31:0] md [logic [15:0]];
        logic [31:0] ins, a, b, s, ea, v;
        logic [15:0] pc, ad;
        int rt_i, rd_i;
        bit done;
        exp_f.delete();
        exp_sa.delete();
        exp_sd.delete();
        exp_ret = 0;
        for (int i = 0; i < 32; i++) r[i] = '0;
        pc = '0;
        done = 0;
        for (int step = 0; step < 3000 && !done; step++) begin
            exp_f.push_back(32'(pc));
            ins = prog[pc[9:2]];
            a = r[ins[25:21]];
            b = r[ins[20:16]];
            s = {{16{ins[15]}}, ins[15:0]};
            rt_i = int'(ins[20:16]);
            rd_i = int'(ins[15:11]);
            ea = a + s;
            ad = {ea[15:2], 2'b00};
            case (ins[31:26])
                OP_R: begin
                    case (ins[10:0])
                        11'd1:   v = a + b;
                        11'd2:   v = a - b;
                        11'd3:   v = a & b;
                        11'd4:   v = a | b;
                        11'd5:   v = a ^ b;
                        11'd6:   v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        default: v = '0;
                    endcase
                    if (rd_i != 0) r[rd_i] = v;
                    pc = pc + 16'd4;
                    exp_ret++;
                end
                OP_ADDI: begin
                    if (rt_i != 0) r[rt_i] = a + s;
                    pc = pc + 16'd4;
                    exp_ret++;
                end
                OP_LW: begin
                    v = md.exists(ad) ? md[ad] : dm_init(ad);
                    if (rt_i != 0) r[rt_i] = v;
                    pc = pc + 16'd4;
                    exp_ret++;
                end
                OP_SW: begin
                    md[ad] = b;
                    exp_sa.push_back(32'(ad));
                    exp_sd.push_back(b);
                    pc = pc + 16'd4;
                    exp_ret++;
                end
                OP_BEQ: begin
                    pc = (a == b) ? 16'(pc + 16'd4 + 16'(s << 2)) : pc + 16'd4;
                    exp_ret++;
                end
                OP_J: begin
                    pc = 16'({ins[25:0], 2'b00});
                    exp_ret++;
                end
                6'b111111: done = 1;
                default: begin
                    pc = pc + 16'd4;
                    exp_ret++;
                end
            endcase
        end
    endtask

    task automatic compare_run(input string tag);
        chk({tag, " nfetch"}, fetch_q.size(), exp_f.size());
        for (int i = 0; i < fetch_q.size() && i < exp_f.size(); i++)
            chk({tag, " fetch"}, fetch_q[i], exp_f[i]);
        chk({tag, " nstore"}, st_a.size(), exp_sa.size());
        for (int i = 0; i < st_a.size() && i < exp_sa.size(); i++) begin
            chk({tag, " st addr"}, st_a[i], exp_sa[i]);
            chk({tag, " st data"}, st_d[i], exp_sd[i]);
        end
        chk({tag, " nretire"}, ret_q.size(), exp_ret);
        chk({tag, " end state"}, 32'(current_state), 5);
        chk({tag, " end imem_req"}, 32'(bus.imem_req), 0);
        chk({tag, " end dmem_req"}, 32'(bus.dmem_req), 0);
    endtask

    task automatic gen_prog(input int n);
        int k, r1, r2, r3;
        clear_prog();
        for (int i = 0; i < n; i++) begin
            k = int'($urandom_range(0, 9));
            r1 = int'($urandom_range(0, 7));
            r2 = int'($urandom_range(0, 7));
            r3 = int'($urandom_range(0, 7));
            case (k)
                0, 1: prog[i] = i_ty(OP_ADDI, r1, r2, int'($urandom_range(0, 65535)));
                2, 3: prog[i] = ir_r(r1, r2, r3, int'($urandom_range(0, 8)));
                4: prog[i] = i_ty(OP_LW, r1, 0, int'($urandom_range(0, 255)));
                5: prog[i] = i_ty(OP_SW, r1, 0, int'($urandom_range(0, 255)));
                6: prog[i] = i_ty($urandom_range(0, 1) ? OP_LW : OP_SW, r1, r2,
                                  int'($urandom_range(0, 65535)));
                7: prog[i] = i_ty(OP_BEQ, r1, r2, int'($urandom_range(0, 2)));
                8: prog[i] = {6'b010101, 26'($urandom)};
                default: prog[i] = {OP_J, 26'(i + 1 + int'($urandom_range(0, 2)))};
            endcase
        end
        for (int r = 1; r < 8; r++)
            prog[n + r - 1] = i_ty(OP_SW, r, 0, 'h300 + 4 * r);
        prog[n + 7] = HALT_W;
    endtask

    initial begin
        int n;
        clear_prog();
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");

        // reset while a load is waiting on the data memory
        clear_prog();
        prog[0] = i_ty(OP_LW, 1, 0, 0);
        wmode = 0;
        start(0);
        dstall = 1;
        n = 0;
        while (current_state != 3'd3 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t1 reach mem", 32'(current_state), 3);
        repeat (2) @(negedge clk);
        chk("t1 req held", 32'(bus.dmem_req), 1);
        rst = 1'b1;
        #1;
        chk("t1 async state", 32'(current_state), 0);
        chk("t1 async dmem_req", 32'(bus.dmem_req), 0);
        chk("t1 async imem_req", 32'(bus.imem_req), 1);
        @(posedge clk);
        #1;
        check_reset("t1");

        // ADDI/ADD zero-wait timing
        clear_prog();
        prog[0] = i_ty(OP_ADDI, 1, 0, 5);
        prog[1] = ir_r(2, 1, 1, 1);
        prog[2] = i_ty(OP_SW, 2, 0, 'h100);
        start(0);
        run_halt("t2", 100);
        chk("t2 nretire", ret_q.size(), 3);
        if (ret_q.size() >= 2) begin
            chk("t2 retire0 cyc", ret_q[0], 4);
            chk("t2 retire1 cyc", ret_q[1], 8);
        end
        chk("t2 nstore", st_a.size(), 1);
        if (st_a.size() >= 1) begin
            chk("t2 st addr", st_a[0], 32'h100);
            chk("t2 r2", st_d[0], 10);
        end

        // instruction memory 3 wait states
        clear_prog();
        start(3);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("t3 state IF", 32'(current_state), 0);
            chk("t3 imem_addr", 32'(bus.imem_addr), 0);
            chk("t3 imem_req", 32'(bus.imem_req), 1);
        end
        @(negedge clk);
        chk("t3 state ID", 32'(current_state), 1);
        chk("t3 not halted", 32'(halted), 0);
        @(negedge clk);
        chk("t3 halted", 32'(halted), 1);

        // store/load with 2-cycle data waits
        clear_prog();
        prog[0] = i_ty(OP_ADDI, 1, 0, 'h40);
        prog[1] = i_ty(OP_ADDI, 3, 0, 'h6F56);
        prog[2] = ir_r(3, 3, 3, 1);
        prog[3] = i_ty(OP_ADDI, 3, 3, 1);
        prog[4] = i_ty(OP_SW, 3, 1, 4);
        prog[5] = i_ty(OP_LW, 4, 1, 4);
        prog[6] = i_ty(OP_SW, 4, 0, 'h100);
        wmode = 2;
        start(2);
        run_halt("t4", 400);
        chk("t4 nstore", st_a.size(), 2);
        if (st_a.size() >= 2) begin
            chk("t4 sw addr", st_a[0], 32'h44);
            chk("t4 sw data", st_d[0], 32'hDEAD);
            chk("t4 lw r4", st_d[1], 32'hDEAD);
        end

        // BEQ r0,r0,-1 spins on pc 0
        clear_prog();
        prog[0] = i_ty(OP_BEQ, 0, 0, 'hFFFF);
        wmode = 0;
        start(0);
        repeat (12) @(negedge clk);
        #1;
        chk("t5 nfetch", fetch_q.size(), 4);
        foreach (fetch_q[i]) chk("t5 loop pc", fetch_q[i], 0);
        chk("t5 nretire", ret_q.size(), 4);
        foreach (ret_q[i]) chk("t5 retire cyc", ret_q[i], 3 * (i + 1));

        // BEQ not taken falls through
        clear_prog();
        prog[0] = i_ty(OP_ADDI, 1, 0, 1);
        prog[1] = i_ty(OP_BEQ, 1, 0, 5);
        model_run();
        start(0);
        run_halt("t5b", 100);
        compare_run("t5b");
        if (fetch_q.size() >= 3) chk("t5b fallthrough", fetch_q[2], 8);

        // r0 stays zero, then HALT
        clear_prog();
        prog[0] = i_ty(OP_ADDI, 0, 0, 7);
        prog[1] = i_ty(OP_SW, 0, 0, 'h100);
        start(0);
        run_halt("t6", 100);
        if (st_d.size() >= 1) chk("t6 r0", st_d[0], 0);
        repeat (5) @(negedge clk);
        #1;
        chk("t6 state", 32'(current_state), 5);
        chk("t6 imem_req", 32'(bus.imem_req), 0);
        chk("t6 dmem_req", 32'(bus.dmem_req), 0);
        chk("t6 nfetch", fetch_q.size(), 3);

        for (int p = 0; p < 10; p++) begin
            wmode = (p == 0) ? 0 : 1;
            gen_prog(40);
            model_run();
            start(nw());
            run_halt("rnd", 4000);
            compare_run("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
